// File: rtl/bitrev_ctrl_if.sv
// Request/response handshake and SPI pins of the bit-reversing SPI controller.
// A transfer on either channel completes on the rising clock edge where valid and ready are both high.
interface bitrev_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_data;
    logic [DIV_W-1:0] div;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             sck;
    logic             ss;
    logic             mosi;
    logic             miso;

    modport master (
        output req_valid, req_data, div, rsp_ready, miso,
        input  req_ready, rsp_valid, rsp_data, sck, ss, mosi
    );

    modport slave (
        input  req_valid, req_data, div, rsp_ready, miso,
        output req_ready, rsp_valid, rsp_data, sck, ss, mosi
    );
endinterface

// File: rtl/bitrev_ctrl.sv
// SPI master that sends a byte LSB first, then clocks it back out of the slave so the
// returned byte is the bit-reverse of the request; every pin and handshake output is a flop.
module bitrev_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic         clock,
    input  logic         reset,
    bitrev_ctrl_if.slave bus,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_SETUP = 3'd2,
        S_XFER  = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       edge_q, edge_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             sck_q, sck_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             tick;
    logic             accept;

    // tick marks the last clock of the current sck half-period
    assign tick   = (cnt_q == div_q);
    assign accept = bus.req_valid && req_ready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            edge_q      <= 5'd0;
            data_q      <= 8'h00;
            rsp_data_q  <= 8'h00;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b1;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            edge_q      <= edge_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_FLUSH;
            S_FLUSH: if (tick && !sck_q) state_d = S_SETUP;
            S_SETUP: if (tick) state_d = S_XFER;
            S_XFER:  if (tick && !sck_q && edge_q == 5'd16) state_d = S_HOLD;
            S_HOLD:  if (tick) state_d = S_DONE;
            S_DONE:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        div_d       = div_q;
        edge_d      = edge_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            S_IDLE: begin
                cnt_d       = '0;
                req_ready_d = !accept;
                if (accept) begin
                    data_d = bus.req_data;
                    div_d  = bus.div;
                    sck_d  = 1'b1;
                    edge_d = 5'd0;
                end
            end
            S_FLUSH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (!sck_q) begin
                        ss_d   = 1'b0;
                        mosi_d = data_q[0];
                    end
                end
            end
            S_SETUP: begin
                if (tick) begin
                    sck_d  = 1'b1;
                    edge_d = 5'd1;
                end
            end
            S_XFER: begin
                if (tick) begin
                    if (sck_q) begin
                        // falling edge: capture the slave's bit, present the next mosi bit
                        sck_d = 1'b0;
                        if (edge_q >= 5'd8 && edge_q <= 5'd15)
                            rsp_data_d[edge_q[2:0]] = bus.miso;
                        mosi_d = (edge_q < 5'd8) ? data_q[edge_q[2:0]] : 1'b1;
                    end else if (edge_q != 5'd16) begin
                        sck_d  = 1'b1;
                        edge_d = edge_q + 5'd1;
                    end
                end
            end
            S_HOLD: begin
                if (tick) begin
                    ss_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.sck       = sck_q;
    assign bus.ss        = ss_q;
    assign bus.mosi      = mosi_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bitrev_ctrl.sv
// Directed bench for bitrev_ctrl: an SPI slave that echoes the received byte last-bit-first,
// a response scoreboard, and pin-timing monitors for sck phases, ss window and latency.
module tb_bitrev_ctrl;
    localparam int DIV_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    int   cyc       = 0;
    int   acc_edge  = 0;
    int   prev_acc  = 0;
    int   cur_h     = 1;
    int   rise_cnt  = 0;
    int   drise     = 0;
    int   last_rise = 0;
    int   run_len   = 0;
    int   ss_low    = 0;
    int   ss_falls  = 0;
    int   rsp_seen  = 0;
    int   rsp_want  = 0;
    logic prev_sck  = 1'b0;
    logic prev_ss   = 1'b1;
    logic prev_vld  = 1'b0;
    bit   chk_phase = 1'b1;

    logic [7:0] rx = 8'h00;
    int         scnt = 0;

    bitrev_ctrl_if #(.DIV_W(DIV_W)) bif ();

    bitrev_ctrl #(.DIV_W(DIV_W)) dut (
        .clock       (clk),
        .reset       (rst),
        .bus         (bif.slave),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI slave: the flush pulse (ss high) restarts it; it records 8 bits then replays them newest first
    always @(posedge bif.sck) begin
        if (bif.ss) begin
            scnt = 0;
        end else begin
            scnt++;
            if (scnt <= 8) rx[scnt-1] = bif.mosi;
            if (scnt >= 8 && scnt <= 15) bif.miso = rx[15-scnt];
        end
    end

    // monitor: scoreboard pop, latency, sck phase lengths, ss window
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.rsp_valid && !prev_vld)
                check("latency", cyc - acc_edge, 36 * cur_h);
            if (bif.rsp_valid && bif.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got 0x%0h expected no response", bif.rsp_data);
                end else begin
                    check("rsp_data", bif.rsp_data, exp_q.pop_front());
                end
                rsp_seen++;
            end
        end
        prev_vld = bif.rsp_valid;

        if (bif.sck !== prev_sck) begin
            if (prev_sck && chk_phase) check("sck_high_len", run_len, cur_h);
            if (bif.sck) begin
                rise_cnt++;
                if (!bif.ss) begin
                    drise++;
                    if (drise >= 2 && chk_phase) check("sck_period", cyc - last_rise, 2 * cur_h);
                    last_rise = cyc;
                end
            end
            run_len = 1;
        end else begin
            run_len++;
        end
        prev_sck = bif.sck;
        if (bif.ss) drise = 0;
        if (!bif.ss) ss_low++;
        if (!bif.ss && prev_ss) ss_falls++;
        prev_ss = bif.ss;
    end

    // driver tasks
    task automatic send(input logic [7:0] d, input int dv, input bit want_rsp, input logic [7:0] exp);
        int n = 0;
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_data  = d;
        bif.div       = dv[DIV_W-1:0];
        while (!bif.req_ready && n < 800) begin
            @(negedge clk);
            n++;
        end
        if (!bif.req_ready) begin
            total++;
            bad++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 800 clocks");
            bif.req_valid = 1'b0;
            return;
        end
        prev_acc = acc_edge;
        acc_edge = cyc + 1;
        cur_h    = dv + 1;
        if (want_rsp) begin
            exp_q.push_back(exp);
            rsp_want++;
        end
        @(posedge clk);
        #1 bif.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (rsp_seen < rsp_want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rsp_seen < rsp_want) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: got %0d responses expected %0d", rsp_seen, rsp_want);
        end
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_data  = 8'h00;
        bif.div       = '0;
        bif.rsp_ready = 1'b1;
        #1 rst = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ss", bif.ss, 1'b1);
        check("rst_sck", bif.sck, 1'b0);
        check("rst_mosi", bif.mosi, 1'b1);
        check("rst_rsp_valid", bif.rsp_valid, 1'b0);
        check("rst_rsp_data", bif.rsp_data, 8'h00);
        check("rst_req_ready", bif.req_ready, 1'b0);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_release", bif.req_ready, 1'b1);

        // single byte, div=0
        rise_cnt = 0; ss_low = 0;
        send(8'h01, 0, 1'b1, 8'h80);
        wait_rsp(100);
        check("rises_div0", rise_cnt, 17);
        check("ss_low_div0", ss_low, 34);

        // divided clock, div=3
        rise_cnt = 0; ss_low = 0;
        send(8'h12, 3, 1'b1, 8'h48);
        wait_rsp(250);
        check("rises_div3", rise_cnt, 17);
        check("ss_low_div3", ss_low, 136);

        // widest divider: H = 256
        rise_cnt = 0; ss_low = 0;
        send(8'h35, 255, 1'b1, 8'hAC);
        wait_rsp(9400);
        check("rises_div255", rise_cnt, 17);
        check("ss_low_div255", ss_low, 34 * 256);

        // backpressure with a competing request
        @(posedge clk);
        #1 bif.rsp_ready = 1'b0;
        send(8'hC3, 0, 1'b1, 8'hC3);
        begin
            int n = 0;
            while (!bif.rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("bp_rsp_valid_rise", bif.rsp_valid, 1'b1);
        end
        bif.req_valid = 1'b1;
        bif.req_data  = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", bif.rsp_valid, 1'b1);
            check("bp_rsp_data", bif.rsp_data, 8'hC3);
            check("bp_req_ready", bif.req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        bif.req_valid = 1'b0;
        bif.rsp_ready = 1'b1;
        wait_rsp(20);
        rise_cnt = 0;
        repeat (4) @(negedge clk);
        check("bp_ignored_state", dbg_state, 3'd0);
        check("bp_ignored_ss", bif.ss, 1'b1);
        check("bp_ignored_sck", rise_cnt, 0);

        // reset after data edge 10, while sck is high
        chk_phase = 1'b0;
        send(8'h3C, 0, 1'b0, 8'h00);
        begin
            int   r = 0;
            int   n = 0;
            logic last;
            last = bif.sck;
            if (bif.sck) r = 1;
            while (r < 11 && n < 200) begin
                @(posedge clk);
                #1;
                if (bif.sck && !last) r++;
                last = bif.sck;
                n++;
            end
            check("abort_edge_reached", r, 11);
            check("abort_sck_high", bif.sck, 1'b1);
        end
        #2 rst = 1'b1;
        #1;
        check("abort_ss", bif.ss, 1'b1);
        check("abort_sck", bif.sck, 1'b0);
        check("abort_mosi", bif.mosi, 1'b1);
        check("abort_req_ready", bif.req_ready, 1'b0);
        check("abort_rsp_data", bif.rsp_data, 8'h00);
        check("abort_state", dbg_state, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_phase = 1'b1;
        send(8'hF0, 0, 1'b1, 8'h0F);
        wait_rsp(100);

        // back-to-back, div=1
        rise_cnt = 0; ss_low = 0; ss_falls = 0;
        send(8'h0F, 1, 1'b1, 8'hF0);
        send(8'hAA, 1, 1'b1, 8'h55);
        check("b2b_spacing", acc_edge - prev_acc, 74);
        wait_rsp(200);
        check("b2b_rises", rise_cnt, 34);
        check("b2b_ss_falls", ss_falls, 2);
        check("b2b_ss_low", ss_low, 136);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
